alu_acc_mc: RTL and testbench
=============================

# alu_acc_mc

Parametrised accumulator ALU: the next-generation datapath execution unit of the Karpentium processor. Holds an internal N-bit accumulator and registered Z/N/C/V status flags, executes single-cycle arithmetic, logic, shift and load ops, plus a multi-cycle unsigned shift-add multiply behind a busy/done handshake. Drives the shared data bus through a tri-state output under an explicit output-enable.

## Interface
- N, 16, data and accumulator width (N ≥ 2)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  issue strobe; op accepted on an edge where enable=1 and busy=0
- select  in  4  opcode (see Operation)
- in  in  N  operand from data bus
- oe  in  1  bus drive enable
- out  out  N  accumulator when oe=1, else high-Z
- flags  out  4  {Z, N, C, V}, registered
- busy  out  1  multiply in progress
- done  out  1  one-cycle pulse when multiply result is written

## Operation
- Opcodes (acc = accumulator, all results mod 2^N):
  - 0000 ADD acc+in; C = carry out; V = signed overflow
  - 0001 SUB acc−in (true two's-complement subtract); C = borrow (in > acc unsigned); V = signed overflow
  - 0010 INC acc+1, flags as ADD with in=1; 0011 DEC acc−1, flags as SUB with in=1
  - 0100 AND, 0101 OR, 0110 XOR with in; C=V=0
  - 0111 SHL acc<<1, C = old acc[N−1]; 1000 SHR logical acc>>1, C = old acc[0]; V=0
  - 1001 MUL acc·in unsigned, multi-cycle; acc = low N bits; C = V = (high N bits ≠ 0)
  - 1010 LOAD acc=in; C=V=0
  - 1011 CLR acc=0; Z=1, N=C=V=0
  - 1100–1111 NOP: acc and flags unchanged
- Z = (result == 0), N = result[N−1], updated by every non-NOP op.
- FSM: IDLE, MUL.
  - IDLE: accept op when enable=1. Non-MUL ops complete in that edge. MUL latches multiplicand=acc, multiplier=in, clears a 2N-bit product and an iteration counter, moves to MUL, busy<=1.
  - MUL: one multiplier bit per edge (shift-add). After the N-th iteration edge: write acc and flags, busy<=0, done<=1, return to IDLE.
- During MUL, enable is ignored (not queued); acc, flags and out keep their pre-MUL values until the result edge.
- out = oe ? acc : 'z, combinational from the acc register; independent of busy.

## Timing
- Reset (rst=1 at an edge): acc=0, flags=0000, busy=0, done=0, FSM=IDLE. rst overrides enable in the same edge.
- Single-cycle op accepted at edge T: acc/flags valid after T.
- MUL accepted at edge T: busy=1 after T through edge T+N; result written at T+N; busy=0 and done=1 for the cycle after T+N; done=0 after T+N+1.
- Back-to-back: a new op may be issued on the edge where done=1 (busy=0).
- Reset mid-MUL: aborts immediately; no done pulse; acc=0.
- MUL with in=0 or acc=0 still takes N cycles; result 0, Z=1, C=V=0.

## Test plan
- Reset: rst=1 one edge -> acc=0x0000, flags=0000, busy=0; oe=0 gives out=Z, oe=1 gives out=0x0000.
- LOAD 0x7FFF then INC -> acc=0x8000, Z=0 N=1 C=0 V=1; then SHL -> acc=0x0000, Z=1 C=1 V=0.
- LOAD 0x0005 then SUB 0x0007 -> acc=0xFFFE, N=1 C=1 V=0; XOR 0xFFFF -> acc=0x0001, C=V=0.
- LOAD 0x0123, MUL 0x0010 -> busy high exactly 16 cycles, ADD 0x0001 issued mid-multiply ignored, acc=0x1230 at result edge, done high exactly 1 cycle, C=V=0.
- LOAD 0x8000, MUL 0x0002 -> acc=0x0000, Z=1, C=V=1, done pulse after 16 busy cycles.
- MUL started, rst=1 on 5th busy cycle -> next cycle busy=0, acc=0, flags=0000, done never asserts.

Source files
------------

// File: rtl/alu_acc_mc.sv
// Accumulator ALU with registered Z/N/C/V flags, single-cycle arithmetic, logic,
// shift and load ops, and a multi-cycle unsigned shift-add multiply behind a
// busy/done handshake. The accumulator drives the shared bus through a tri-state port.
module alu_acc_mc #(
    parameter int unsigned N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic [3:0]   select,
    input  logic [N-1:0] in,
    input  logic         oe,
    output logic [N-1:0] out,
    output logic [3:0]   flags,
    output logic         busy,
    output logic         done
);

    localparam int unsigned CntW = $clog2(N);

    localparam logic [3:0] OpAdd  = 4'b0000;
    localparam logic [3:0] OpSub  = 4'b0001;
    localparam logic [3:0] OpInc  = 4'b0010;
    localparam logic [3:0] OpDec  = 4'b0011;
    localparam logic [3:0] OpAnd  = 4'b0100;
    localparam logic [3:0] OpOr   = 4'b0101;
    localparam logic [3:0] OpXor  = 4'b0110;
    localparam logic [3:0] OpShl  = 4'b0111;
    localparam logic [3:0] OpShr  = 4'b1000;
    localparam logic [3:0] OpMul  = 4'b1001;
    localparam logic [3:0] OpLoad = 4'b1010;
    localparam logic [3:0] OpClr  = 4'b1011;

    typedef enum logic [0:0] {
        StIdle,
        StMul
    } state_e;

    state_e            state_q, state_d;
    logic [N-1:0]      acc_q, acc_d;
    logic [3:0]        flags_q, flags_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [2*N-1:0]    mcand_q, mcand_d;
    logic [N-1:0]      mplier_q, mplier_d;
    logic [2*N-1:0]    prod_q, prod_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    // Single-cycle datapath temporaries
    logic [N-1:0]      opnd_b;
    logic [N:0]        sum;
    logic [N-1:0]      diff;
    logic              add_v;
    logic              sub_v;
    logic              borrow;
    logic [N-1:0]      res;
    logic              res_c;
    logic              res_v;
    logic              res_upd;
    logic [2*N-1:0]    prod_step;

    // Single-cycle op result and carry/overflow, independent of FSM state
    always_comb begin
        opnd_b  = ((select == OpInc) || (select == OpDec)) ? N'(1) : in;
        sum     = {1'b0, acc_q} + {1'b0, opnd_b};
        diff    = acc_q - opnd_b;
        add_v   = (acc_q[N-1] == opnd_b[N-1]) && (sum[N-1] != acc_q[N-1]);
        sub_v   = (acc_q[N-1] != opnd_b[N-1]) && (diff[N-1] != acc_q[N-1]);
        borrow  = opnd_b > acc_q;
        res     = acc_q;
        res_c   = 1'b0;
        res_v   = 1'b0;
        res_upd = 1'b1;
        case (select)
            OpAdd, OpInc: begin
                res   = sum[N-1:0];
                res_c = sum[N];
                res_v = add_v;
            end
            OpSub, OpDec: begin
                res   = diff;
                res_c = borrow;
                res_v = sub_v;
            end
            OpAnd:  res = acc_q & in;
            OpOr:   res = acc_q | in;
            OpXor:  res = acc_q ^ in;
            OpShl: begin
                res   = {acc_q[N-2:0], 1'b0};
                res_c = acc_q[N-1];
            end
            OpShr: begin
                res   = {1'b0, acc_q[N-1:1]};
                res_c = acc_q[0];
            end
            OpLoad: res = in;
            OpClr:  res = '0;
            // MUL is handled by the FSM; 1100-1111 are NOPs
            default: res_upd = 1'b0;
        endcase
    end

    // Next-state logic for the IDLE/MUL controller and the shift-add multiplier
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        flags_d   = flags_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        prod_d    = prod_q;
        cnt_d     = cnt_q;
        prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);

        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    if (select == OpMul) begin
                        mcand_d  = {{N{1'b0}}, acc_q};
                        mplier_d = in;
                        prod_d   = '0;
                        cnt_d    = '0;
                        busy_d   = 1'b1;
                        state_d  = StMul;
                    end else if (res_upd) begin
                        acc_d   = res;
                        flags_d = {(res == '0), res[N-1], res_c, res_v};
                    end
                end
            end
            StMul: begin
                // One multiplier bit per edge; enable is ignored here
                prod_d   = prod_step;
                mcand_d  = {mcand_q[2*N-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[N-1:1]};
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CntW'(N - 1)) begin
                    acc_d   = prod_step[N-1:0];
                    flags_d = {(prod_step[N-1:0] == '0), prod_step[N-1],
                               (prod_step[2*N-1:N] != '0), (prod_step[2*N-1:N] != '0)};
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset; reset also aborts a multiply in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            flags_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            flags_q  <= flags_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out   = oe ? acc_q : 'z;
    assign flags = flags_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_alu_acc_mc.sv
// Scoreboard bench for alu_acc_mc: stimulus pushes expected results, a monitor
// pops and compares them when the DUT presents a result.
module tb_alu_acc_mc;

    localparam int unsigned N = 16;

    logic         clk;
    logic         rst;
    logic         enable;
    logic [3:0]   select;
    logic [N-1:0] in_d;
    logic         oe;
    logic [N-1:0] out;
    logic [3:0]   flags;
    logic         busy;
    logic         done;

    typedef struct {
        bit           is_mul;
        logic [N-1:0] acc;
        logic [3:0]   flg;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_acc_mc #(.N(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .select (select),
        .in     (in_d),
        .oe     (oe),
        .out    (out),
        .flags  (flags),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Single-cycle op: called at a negedge, returns at the following negedge
    task automatic do_op(input logic [3:0] sel, input logic [N-1:0] val,
                         input logic [N-1:0] ea, input logic [3:0] ef);
        exp_t e;
        select = sel;
        in_d   = val;
        enable = 1'b1;
        @(posedge clk);
        e.is_mul = 1'b0;
        e.acc    = ea;
        e.flg    = ef;
        sb.push_back(e);
        @(negedge clk);
        enable = 1'b0;
    endtask

    // Multiply: returns at the negedge where busy has dropped (done should be high)
    task automatic do_mul(input logic [N-1:0] val, input logic [N-1:0] pre,
                          input logic [N-1:0] ea, input logic [3:0] ef, input bit inject);
        exp_t e;
        int   cnt;
        select = 4'b1001;
        in_d   = val;
        enable = 1'b1;
        @(posedge clk);
        e.is_mul = 1'b1;
        e.acc    = ea;
        e.flg    = ef;
        sb.push_back(e);
        @(negedge clk);
        enable = 1'b0;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (!busy) break;
            cnt++;
            check("acc_hold_during_mul", out, pre);
            if (inject && cnt == 5) begin
                select = 4'b0000;
                in_d   = 16'h0001;
                enable = 1'b1;
            end else begin
                enable = 1'b0;
            end
            @(negedge clk);
        end
        enable = 1'b0;
        check("busy_cycles", cnt, 16);
        check("done_after_busy", done, 1);
    endtask

    // Monitor: single-cycle results checked the negedge after issue, MUL results on done
    initial begin
        exp_t e;
        bit   prev_done = 1'b0;
        int   mul_wait  = 0;
        forever begin
            @(negedge clk);
            if (prev_done) check("done_pulse_width", done, 0);
            prev_done = done;
            if (done) begin
                check("done_expected", (sb.size() > 0 && sb[0].is_mul) ? 1 : 0, 1);
                if (sb.size() > 0 && sb[0].is_mul) begin
                    e = sb.pop_front();
                    check("mul_acc", out, e.acc);
                    check("mul_flags", flags, e.flg);
                    mul_wait = 0;
                end
            end else if (sb.size() > 0) begin
                if (!sb[0].is_mul) begin
                    e = sb.pop_front();
                    check("op_acc", out, e.acc);
                    check("op_flags", flags, e.flg);
                end else begin
                    mul_wait++;
                    if (mul_wait > 40) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL mul_timeout: got no done, want done within 40 cycles");
                        void'(sb.pop_front());
                        mul_wait = 0;
                    end
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst    = 1'b1;
        enable = 1'b0;
        select = 4'b0000;
        in_d   = '0;
        oe     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_acc", out, 16'h0000);
        check("reset_flags", flags, 4'b0000);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);

        // Signed overflow on INC, shift out of msb
        do_op(4'b1010, 16'h7FFF, 16'h7FFF, 4'b0000);
        do_op(4'b0010, 16'h0000, 16'h8000, 4'b0101);
        do_op(4'b0111, 16'h0000, 16'h0000, 4'b1010);
        // Borrow on SUB, then logic ops
        do_op(4'b1010, 16'h0005, 16'h0005, 4'b0000);
        do_op(4'b0001, 16'h0007, 16'hFFFE, 4'b0110);
        do_op(4'b0110, 16'hFFFF, 16'h0001, 4'b0000);
        do_op(4'b0000, 16'hFFFF, 16'h0000, 4'b1010);
        do_op(4'b0011, 16'h0000, 16'hFFFF, 4'b0110);
        do_op(4'b0100, 16'h0F0F, 16'h0F0F, 4'b0000);
        do_op(4'b0101, 16'hF000, 16'hFF0F, 4'b0100);
        do_op(4'b1000, 16'h0000, 16'h7F87, 4'b0010);
        do_op(4'b1011, 16'h5555, 16'h0000, 4'b1000);
        do_op(4'b1100, 16'h1234, 16'h0000, 4'b1000);
        do_op(4'b1010, 16'h8000, 16'h8000, 4'b0100);
        do_op(4'b0001, 16'h0001, 16'h7FFF, 4'b0001);

        // Multiply with an ignored mid-multiply ADD
        do_op(4'b1010, 16'h0123, 16'h0123, 4'b0000);
        do_mul(16'h0010, 16'h0123, 16'h1230, 4'b0000, 1'b1);
        // Back-to-back issue on the done cycle; multiply overflow
        do_op(4'b1010, 16'h8000, 16'h8000, 4'b0100);
        do_mul(16'h0002, 16'h8000, 16'h0000, 4'b1011, 1'b0);
        // Zero multiplier still takes N cycles
        do_op(4'b1010, 16'h1234, 16'h1234, 4'b0000);
        do_mul(16'h0000, 16'h1234, 16'h0000, 4'b1000, 1'b0);

        // Reset on the 5th busy cycle aborts the multiply
        do_op(4'b1010, 16'h00FF, 16'h00FF, 4'b0000);
        select = 4'b1001;
        in_d   = 16'h0003;
        enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (busy) cnt++;
            if (cnt == 5) begin
                rst = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("abort_busy_cycles_seen", cnt, 5);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_acc", out, 16'h0000);
        check("abort_flags", flags, 4'b0000);
        for (int k = 0; k < 20; k++) begin
            check("abort_no_done", done, 0);
            @(negedge clk);
        end

        repeat (2) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
